// File: rtl/processor_if.sv
// ---------------------------------------------------------------------------
// processor_if
//   Pin bundle of the processor tile. The harness side (master) drives the
//   enable and operand pins; the processor side (slave) returns the result
//   and the bidirectional-pin controls.
//
//   ena      1  clock enable, 0 holds all state
//   ui_in    8  operand A, unsigned
//   uio_in   8  [7:5] opcode, [4:0] operand B
//   uo_out   8  registered result
//   uio_out  8  constant 0
//   uio_oe   8  constant 0 (bidirectional pins are inputs only)
// ---------------------------------------------------------------------------
interface processor_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/processor.sv
// ---------------------------------------------------------------------------
// processor
//   8-bit ALU tile. Each enabled cycle it combines operand A (ui_in) with the
//   zero-extended 5-bit operand B (uio_in[4:0]) according to the 3-bit opcode
//   (uio_in[7:5]) and registers the result onto uo_out. Opcode 111 adds A to
//   an internal 8-bit accumulator and writes the sum back to it.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//     bus    processor_if.slave: ena, ui_in, uio_in -> uo_out, uio_out, uio_oe
//
//   Build option:
//     PROC_PIPE_EN  defined   -> input register stage, 2-cycle latency
//                   undefined -> single result register, 1-cycle latency
// ---------------------------------------------------------------------------
module processor (
    input  logic           clk,
    input  logic           rst_n,
    processor_if.slave     bus
);

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_ACC = 3'b111;

    // All arithmetic wraps modulo 256; MUL uses only the low nibbles so the
    // product always fits in 8 bits.
    function automatic logic [DATA_W-1:0] alu_result(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] acc
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MUL:  r = {4'b0000, a[3:0]} * {4'b0000, b[3:0]};
            OP_SHL:  r = a << b[2:0];
            default: r = acc + a;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] res_p1;
    logic [DATA_W-1:0] a_ex;
    logic [DATA_W-1:0] b_ex;
    logic [2:0]        op_ex;
    logic [DATA_W-1:0] res_ex;

`ifdef PROC_PIPE_EN
    // ---- stage p0: operand capture ----
    // Zeroed registers decode as ADD 0+0, so the output stays 0 while the
    // pipeline refills after reset.
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [2:0]        op_p0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_p0  <= '0;
            b_p0  <= '0;
            op_p0 <= OP_ADD;
        end else if (bus.ena) begin
            a_p0  <= bus.ui_in;
            b_p0  <= {3'b000, bus.uio_in[4:0]};
            op_p0 <= bus.uio_in[7:5];
        end
    end

    assign a_ex  = a_p0;
    assign b_ex  = b_p0;
    assign op_ex = op_p0;
`else
    assign a_ex  = bus.ui_in;
    assign b_ex  = {3'b000, bus.uio_in[4:0]};
    assign op_ex = bus.uio_in[7:5];
`endif

    assign res_ex = alu_result(op_ex, a_ex, b_ex, acc_q);

    // ---- stage p1: execute / result register ----
    // The accumulator is written at this same edge, so back-to-back ACC
    // operations see the previous sum without a bubble in either build.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_p1 <= '0;
            acc_q  <= '0;
        end else if (bus.ena) begin
            res_p1 <= res_ex;
            if (op_ex == OP_ACC) begin
                acc_q <= res_ex;
            end
        end
    end

    assign bus.uo_out  = res_p1;
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_processor.sv
// ---------------------------------------------------------------------------
// tb_processor
//   Directed, table-driven bench for the processor tile. Vectors carry
//   opcode, A, B and the hand-computed result; they are streamed one per
//   cycle and each result is checked LAT cycles later. Reset, enable-hold
//   and mid-stream reset are covered by short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_processor;

`ifdef PROC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [4:0] b;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 22;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [0:NV-1];

    processor_if bus ();

    processor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [4:0] b);
        bus.ui_in  = a;
        bus.uio_in = {op, b};
    endtask

    // Streams vecs[lo..hi] back-to-back starting at a negedge; result of
    // vector i is sampled at the negedge LAT cycles after it was driven.
    // Drain cycles drive ADD 0+0, which leaves the accumulator untouched.
    task automatic run_stream(input int lo, input int hi);
        int cnt;
        cnt = hi - lo + 1;
        for (int k = 0; k < cnt + LAT; k++) begin
            if (k >= LAT)
                check($sformatf("vec%0d", lo + k - LAT), bus.uo_out, vecs[lo + k - LAT].exp);
            if (k < cnt)
                drive(vecs[lo + k].op, vecs[lo + k].a, vecs[lo + k].b);
            else
                drive(3'b000, 8'h00, 5'h00);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{3'b111, 8'h00, 5'h1F, 8'h00};  // ACC 0 after reset
        vecs[1]  = '{3'b000, 8'd3,  5'd2,  8'd5};
        vecs[2]  = '{3'b000, 8'd1,  5'd4,  8'd5};
        vecs[3]  = '{3'b000, 8'd5,  5'd3,  8'd8};
        vecs[4]  = '{3'b000, 8'd7,  5'd2,  8'd9};
        vecs[5]  = '{3'b000, 8'd0,  5'd0,  8'd0};
        vecs[6]  = '{3'b000, 8'd1,  5'd1,  8'd2};
        vecs[7]  = '{3'b001, 8'hF6, 5'h13, 8'hE3};  // SUB
        vecs[8]  = '{3'b010, 8'hF6, 5'h13, 8'h12};  // AND
        vecs[9]  = '{3'b011, 8'hF6, 5'h13, 8'hF7};  // OR
        vecs[10] = '{3'b100, 8'hF6, 5'h13, 8'hE5};  // XOR
        vecs[11] = '{3'b101, 8'hF6, 5'h13, 8'h12};  // MUL 6*3
        vecs[12] = '{3'b110, 8'hF6, 5'h13, 8'hB0};  // SHL 3
        vecs[13] = '{3'b000, 8'hFF, 5'h01, 8'h00};  // ADD wrap
        vecs[14] = '{3'b001, 8'h00, 5'h01, 8'hFF};  // SUB borrow
        vecs[15] = '{3'b111, 8'h80, 5'h05, 8'h80};  // ACC, B ignored
        vecs[16] = '{3'b000, 8'h01, 5'h01, 8'h02};  // ADD leaves acc alone
        vecs[17] = '{3'b111, 8'h90, 5'h1F, 8'h10};
        vecs[18] = '{3'b111, 8'h10, 5'h00, 8'h20};
        vecs[19] = '{3'b111, 8'h01, 5'h00, 8'h21};  // acc held through ena=0
        vecs[20] = '{3'b111, 8'h02, 5'h00, 8'h23};
        vecs[21] = '{3'b111, 8'h05, 5'h00, 8'h05};  // after mid-stream reset

        // Reset with random inputs, enable high
        rst_n   = 1'b1;
        bus.ena = 1'b1;
        drive(3'($urandom_range(0, 7)), 8'($urandom), 5'($urandom));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rst_uo%0d", i), bus.uo_out, 8'h00);
            check($sformatf("rst_oe%0d", i), bus.uio_oe, 8'h00);
            check($sformatf("rst_uio%0d", i), bus.uio_out, 8'h00);
            drive(3'($urandom_range(0, 7)), 8'($urandom), 5'($urandom));
        end
        rst_n = 1'b0;

        run_stream(0, 18);

        // Enable hold: fill with XOR 0x55^0x0A, then freeze with changing ACC inputs
        drive(3'b100, 8'h55, 5'h0A);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("ena_fill", bus.uo_out, 8'h5F);
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(3'b111, 8'h33 + 8'(i), 5'(i));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("ena_hold%0d", i), bus.uo_out, 8'h5F);
        end
        bus.ena = 1'b1;
        drive(3'b000, 8'h10, 5'h01);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        check("ena_resume", bus.uo_out, 8'h11);

        run_stream(19, 20);

        // Reset in the middle of an ACC sequence discards the in-flight op
        drive(3'b111, 8'h40, 5'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_uo", bus.uo_out, 8'h00);
        check("midrst_oe", bus.uio_oe, 8'h00);
        rst_n = 1'b0;

        run_stream(21, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
